// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//  - fq_state_e : fetch controller states (idle / issuing / discarding in-flight)
//  - FQ_PC_W, FQ_INST_W : default address and instruction widths
package fetch_pkg;
   localparam int FQ_PC_W   = 16;
   localparam int FQ_INST_W = 16;

   typedef enum logic [1:0] {
      FQ_IDLE  = 2'd0,
      FQ_RUN   = 2'd1,
      FQ_FLUSH = 2'd2
   } fq_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with push/pop/clear and occupancy outputs.
// Ports:
//  clk, reset       clock, asynchronous active-low reset
//  clear            drop all entries (wins over push/pop)
//  push, wdata      write request and data (accepted if not full, or full with pop)
//  pop              read request (ignored when empty)
//  rdata            head entry (undefined contents when empty)
//  count            number of entries, 0..DEPTH
//  empty, full      occupancy flags
// DEPTH must be a power of 2 and >= 2 so the pointers wrap naturally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int W     = FQ_PC_W,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: nothing is read out until count says it was written.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: buffered instruction-fetch stage between imem and decode.
// Owns the PC, issues pipelined req/gnt requests, tracks issued addresses in a
// small address FIFO and holds returned {addr,word} pairs in a prefetch queue.
// A redirect reloads the PC, clears the queue and discards in-flight responses.
// Ports:
//  clk, reset                      clock, asynchronous active-low reset
//  enable                          allow new requests
//  redirect_valid, redirect_pc     taken branch and its target
//  imem_req, imem_addr, imem_gnt   request handshake (addr = current PC)
//  imem_rvalid, imem_rdata         in-order responses
//  inst_valid, inst_ready          decode handshake on the queue head
//  inst_code, inst_pc              head word and its address (0 when empty)
// Optional (macro FETCH_QUEUE_STATS_EN):
//  stat_fetched                    saturating count of words taken by decode
//  stat_stall                      saturating count of RUN cycles without a handshake
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int              PC_W      = FQ_PC_W,
   parameter int              INST_W    = FQ_INST_W,
   parameter int              DEPTH     = 4,
   parameter int              MAX_OUT   = 2,
   parameter logic [PC_W-1:0] BOOT_ADDR = '0,
   parameter int              PC_STEP   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_code,
   output logic [PC_W-1:0]   inst_pc
`ifdef FETCH_QUEUE_STATS_EN
   ,
   output logic [31:0]       stat_fetched,
   output logic [31:0]       stat_stall
`endif
);
   localparam int AC_W = $clog2(MAX_OUT);
   localparam int QC_W = $clog2(DEPTH);

   fq_state_e              state;
   logic [PC_W-1:0]        pc;
   logic                   fire, resp, q_push, q_pop, last_resp;
   logic                   a_empty, a_full, q_empty, q_full;
   logic [AC_W:0]          a_cnt;
   logic [QC_W:0]          q_cnt;
   logic [PC_W-1:0]        a_head;
   logic [PC_W+INST_W-1:0] q_head;

   // Credit rule: every outstanding request already owns a queue slot.
   assign imem_req  = (state == FQ_RUN) && !redirect_valid && !a_full && !q_full &&
                      (int'(q_cnt) + int'(a_cnt) < DEPTH);
   assign imem_addr = pc;
   assign fire      = imem_req && imem_gnt;
   // A response with nothing outstanding (e.g. issued before a reset) is ignored.
   assign resp      = imem_rvalid && !a_empty;
   assign q_push    = resp && (state != FQ_FLUSH);
   assign q_pop     = inst_valid && inst_ready;
   // Nothing left to discard after this edge (no issue is possible in FLUSH).
   assign last_resp = (a_cnt == '0) || ((a_cnt == (AC_W+1)'(1)) && resp);

   fetch_fifo #(.W(PC_W), .DEPTH(MAX_OUT)) u_addr_fifo (
      .clk(clk), .reset(reset), .clear(1'b0), .push(fire), .pop(resp),
      .wdata(pc), .rdata(a_head), .count(a_cnt), .empty(a_empty), .full(a_full)
   );

   // Clear on redirect beats a same-cycle push; a same-cycle pop still completes.
   fetch_fifo #(.W(PC_W+INST_W), .DEPTH(DEPTH)) u_inst_fifo (
      .clk(clk), .reset(reset), .clear(redirect_valid), .push(q_push), .pop(q_pop),
      .wdata({a_head, imem_rdata}), .rdata(q_head), .count(q_cnt),
      .empty(q_empty), .full(q_full)
   );

   assign inst_valid = !q_empty;
   assign inst_pc    = inst_valid ? q_head[PC_W+INST_W-1:INST_W] : '0;
   assign inst_code  = inst_valid ? q_head[INST_W-1:0] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FQ_IDLE;
         pc    <= BOOT_ADDR;
      end else begin
         if (redirect_valid) pc <= redirect_pc;
         else if (fire)      pc <= pc + PC_W'(PC_STEP);

         case (state)
            FQ_IDLE, FQ_RUN: begin
               if (redirect_valid && ((a_cnt != '0) || fire)) state <= FQ_FLUSH;
               else                                          state <= enable ? FQ_RUN : FQ_IDLE;
            end
            FQ_FLUSH: begin
               if (last_resp) state <= enable ? FQ_RUN : FQ_IDLE;
            end
            default: state <= FQ_IDLE;
         endcase
      end
   end

`ifdef FETCH_QUEUE_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_fetched <= '0;
         stat_stall   <= '0;
      end else begin
         if (q_pop && (stat_fetched != '1)) stat_fetched <= stat_fetched + 1'b1;
         if ((state == FQ_RUN) && !fire && (stat_stall != '1)) stat_stall <= stat_stall + 1'b1;
      end
   end
`endif
endmodule
